// File: rtl/rsc_encoder_term_if.sv
// rsc_encoder_term_if: bit-serial valid/ready input and output streams of the RSC encoder.
interface rsc_encoder_term_if;
    logic in_bit;
    logic in_valid;
    logic in_last;
    logic in_ready;
    logic out_sys;
    logic out_par;
    logic out_valid;
    logic out_last;
    logic out_tail;
    logic out_ready;
    modport master (
        output in_bit, in_valid, in_last, out_ready,
        input  in_ready, out_sys, out_par, out_valid, out_last, out_tail
    );
    modport slave (
        input  in_bit, in_valid, in_last, out_ready,
        output in_ready, out_sys, out_par, out_valid, out_last, out_tail
    );
endinterface

// File: rtl/rsc_encoder_term.sv
// rsc_encoder_term: 8-state LTE RSC encoder, g0=1+D^2+D^3, g1=1+D+D^3, one output register.
// Define RSC_TERMINATE_EN to append 3 trellis-termination tail bits after each block.
module rsc_encoder_term #(
    parameter int N_MAX = 6144,
    parameter int LEN_W = 13
) (
    input  logic             clk,
    input  logic             rst,
    rsc_encoder_term_if.slave io,
    output logic [LEN_W-1:0] blk_len,
    output logic             len_err
);
    localparam logic [LEN_W-1:0] NM = LEN_W'(N_MAX);
    logic s1, s2, s3;
    logic [LEN_W-1:0] cnt, cnt_nxt;
    logic load, in_fire, tail_ld, last_out, u, a, z;
    assign load    = !io.out_valid | io.out_ready;
    assign in_fire = io.in_valid & io.in_ready;
`ifdef RSC_TERMINATE_EN
    typedef enum logic {DATA, TAIL} st_t;
    st_t st, st_nxt;
    logic [1:0] tc;
    assign io.in_ready = (st == DATA) & load;
    assign tail_ld     = (st == TAIL) & load;
    assign last_out    = tail_ld & (tc == 2'd2);
    always_comb begin
        st_nxt = st;
        if (st == DATA && in_fire && io.in_last)
            st_nxt = TAIL;
        else if (last_out)
            st_nxt = DATA;
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            st <= DATA;
            tc <= 2'd0;
        end else begin
            st <= st_nxt;
            if (tail_ld)
                tc <= last_out ? 2'd0 : tc + 2'd1;
        end
    end
`else
    assign io.in_ready = load;
    assign tail_ld     = 1'b0;
    assign last_out    = in_fire & io.in_last;
`endif
    // tail bits force the feedback sum a to zero, flushing the register
    assign u       = tail_ld ? (s2 ^ s3) : io.in_bit;
    assign a       = u ^ s2 ^ s3;
    assign z       = a ^ s1 ^ s3;
    assign cnt_nxt = (cnt == NM) ? NM : cnt + 1'b1;
    always_ff @(posedge clk) begin
        if (rst) begin
            {s1, s2, s3} <= 3'b000;
            cnt          <= '0;
            blk_len      <= '0;
            len_err      <= 1'b0;
            io.out_valid <= 1'b0;
            io.out_sys   <= 1'b0;
            io.out_par   <= 1'b0;
            io.out_last  <= 1'b0;
            io.out_tail  <= 1'b0;
        end else begin
            if (load) begin
                io.out_valid <= in_fire | tail_ld;
                io.out_sys   <= u;
                io.out_par   <= z;
                io.out_last  <= last_out;
                io.out_tail  <= tail_ld;
            end
            if (last_out)
                {s1, s2, s3} <= 3'b000;
            else if (in_fire | tail_ld)
                {s1, s2, s3} <= {a, s1, s2};
            if (in_fire) begin
                if (cnt == NM)
                    len_err <= 1'b1;
                if (io.in_last) begin
                    blk_len <= cnt_nxt;
                    cnt     <= '0;
                end else begin
                    cnt <= cnt_nxt;
                end
            end
        end
    end
endmodule

// File: tb/tb_rsc_encoder_term.sv
// tb_rsc_encoder_term: scoreboard bench; driver pushes expected (sys,par,last,tail), monitor pops on out_fire.
module tb_rsc_encoder_term;
    localparam int N_MAX = 6144;
    localparam int LEN_W = 13;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;
    rsc_encoder_term_if io();
    logic [LEN_W-1:0] blk_len;
    logic len_err;
    rsc_encoder_term #(.N_MAX(N_MAX), .LEN_W(LEN_W)) dut (
        .clk(clk), .rst(rst), .io(io), .blk_len(blk_len), .len_err(len_err)
    );
    int tests = 0;
    int fails = 0;
    logic [3:0] q[$];
    logic [2:0] ms = 3'b000;
    bit rnd_rdy = 1'b0;
    bit stall = 1'b0;
    logic [4:0] held;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // reference trellis, {s1,s2,s3} = ms[2:0]
    task automatic model(input bit u, input bit last);
        logic a, z, ut;
        a = u ^ ms[1] ^ ms[0];
        z = a ^ ms[2] ^ ms[0];
`ifdef RSC_TERMINATE_EN
        q.push_back({u, z, 1'b0, 1'b0});
        ms = {a, ms[2:1]};
        if (last) begin
            for (int k = 0; k < 3; k++) begin
                ut = ms[1] ^ ms[0];
                z  = ms[2] ^ ms[0];
                q.push_back({ut, z, k == 2, 1'b1});
                ms = {1'b0, ms[2:1]};
            end
            ms = 3'b000;
        end
`else
        q.push_back({u, z, last, 1'b0});
        ms = last ? 3'b000 : {a, ms[2:1]};
`endif
    endtask

    task automatic send(input bit u, input bit last, input bit push, output int waits);
        bit fired;
        io.in_bit = u;
        io.in_valid = 1'b1;
        io.in_last = last;
        waits = 0;
        fired = 1'b0;
        while (!fired && waits < 1000) begin
            @(negedge clk);
            if (io.in_ready) fired = 1'b1;
            else waits++;
        end
        if (!fired) check("in_ready_timeout", 0, 1);
        if (push && fired) model(u, last);
        @(posedge clk);
        #1;
        io.in_valid = 1'b0;
        io.in_last = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while (q.size() != 0 && n < 500) begin
            @(posedge clk);
            n++;
        end
        check("drain_empty", q.size(), 0);
        @(posedge clk);
        #1;
    endtask

    task automatic t1();
        int w;
        q.push_back(4'b1100);
        q.push_back(4'b0100);
`ifdef RSC_TERMINATE_EN
        q.push_back(4'b0100);
        q.push_back(4'b1001);
        q.push_back(4'b1001);
        q.push_back(4'b1111);
`else
        q.push_back(4'b0110);
`endif
        send(1, 0, 0, w); check("t1_in_ready_b0", w, 0);
        send(0, 0, 0, w); check("t1_in_ready_b1", w, 0);
        send(0, 1, 0, w); check("t1_in_ready_b2", w, 0);
        drain();
        check("t1_blk_len", blk_len, 3);
    endtask

    initial begin
        io.out_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            io.out_ready = rnd_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
        end
    end

    initial begin
        logic [3:0] cur;
        forever begin
            @(negedge clk);
            cur = {io.out_sys, io.out_par, io.out_last, io.out_tail};
            if (rst) begin
                stall = 1'b0;
            end else begin
                if (stall) check("stall_hold", {io.out_valid, cur}, held);
                stall = io.out_valid & !io.out_ready;
                held = {io.out_valid, cur};
                if (io.out_valid && io.out_ready) begin
                    if (q.size() == 0) check("unexpected_out", cur, 4'hx);
                    else check("out_bits", cur, q.pop_front());
                end
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int w, lo;
        logic [4:0] b5;
        logic [6:0] b7;
        logic [12:0] iv;
        io.in_bit = 1'b0;
        io.in_valid = 1'b0;
        io.in_last = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check("rst_out_valid", io.out_valid, 0);
        check("rst_in_ready", io.in_ready, 1);
        check("rst_out_flags", {io.out_sys, io.out_par, io.out_last, io.out_tail}, 0);
        check("rst_blk_len", blk_len, 0);
        check("rst_len_err", len_err, 0);
        @(posedge clk);
        #1;
        t1();
        // single-bit block, with in_ready low across the tail
        q.push_back(4'b1100 | 4'(`ifdef RSC_TERMINATE_EN 0 `else 2 `endif));
`ifdef RSC_TERMINATE_EN
        q.push_back(4'b0101);
        q.push_back(4'b1001);
        q.push_back(4'b1111);
`endif
        send(1, 1, 0, w);
        lo = 0;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            if (!io.in_ready) lo++;
            else break;
        end
`ifdef RSC_TERMINATE_EN
        check("t2_in_ready_low", lo, 3);
`else
        check("t2_in_ready_low", lo, 0);
`endif
        @(posedge clk);
        #1;
        drain();
        check("t2_blk_len", blk_len, 1);
        rnd_rdy = 1'b1;
        for (int i = 0; i < 40; i++) send(1'($urandom_range(0, 1)), i == 39, 1, w);
        drain();
        rnd_rdy = 1'b0;
        @(posedge clk);
        #1;
        check("t3_blk_len", blk_len, 40);
        b5 = 5'b10110;
        b7 = 7'b1100101;
        for (int i = 0; i < 5; i++) send(b5[i], i == 4, 1, w);
        check("t4_blk_len5", blk_len, 5);
        for (int i = 0; i < 7; i++) send(b7[i], i == 6, 1, w);
        check("t4_blk_len7", blk_len, 7);
        drain();
        for (int i = 1; i <= N_MAX + 1; i++) begin
            iv = 13'(i);
            send(iv[0] ^ iv[3], i == N_MAX + 1, 1, w);
            if (i == N_MAX) check("t5_len_err_pre", len_err, 0);
        end
        check("t5_len_err", len_err, 1);
        check("t5_blk_len", blk_len, N_MAX);
        drain();
`ifdef RSC_TERMINATE_EN
        send(1, 1, 1, w);
        @(posedge clk);
        #1;
`else
        send(1, 0, 1, w);
        send(0, 0, 1, w);
`endif
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        q.delete();
        ms = 3'b000;
        @(negedge clk);
        check("t6_out_valid", io.out_valid, 0);
        check("t6_in_ready", io.in_ready, 1);
        check("t6_len_err", len_err, 0);
        @(posedge clk);
        #1;
        t1();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
